// File: rtl/regression_error_stats.sv
// Error statistics for a regression run: accumulates the sum of squared
// residuals over N_SAMPLES samples, then divides by N_SAMPLES with a
// 40-cycle restoring divider to produce a saturated mean squared error.
// Optional max-|err| tracking is enabled by defining ERR_MAX_TRACK_EN.
module regression_error_stats #(
  parameter int unsigned N_SAMPLES = 150,
  parameter int unsigned W         = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         err_valid,
  input  logic [W-1:0] err,
  output logic         busy,
  output logic         done,
  output logic [7:0]   sample_cnt,
  output logic [39:0]  sse,
  output logic [W-1:0] mse,
  output logic [W-1:0] max_abs,
  output logic [7:0]   max_idx
);

  localparam logic [7:0] LastIdx = 8'(N_SAMPLES - 1);
  localparam logic [8:0] Divisor = 9'(N_SAMPLES);

  typedef enum logic [1:0] {StIdle, StAcc, StDiv, StDone} state_e;

  state_e         state_q, state_d;
  logic [39:0]    sse_q, sse_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [W-1:0]   mse_q, mse_d;
  logic [39:0]    quo_q, quo_d;
  logic [8:0]     rem_q, rem_d;
  logic [5:0]     bit_q, bit_d;

  logic           accept;
  logic           run_clear;
  logic [39:0]    err_ext;
  logic [39:0]    sq;
  logic [39:0]    sq_shr;
  logic [8:0]     rem_sh;
  logic           rem_ge;
  logic [8:0]     rem_nxt;
  logic [39:0]    quo_nxt;

  assign accept    = (state_q == StAcc) && err_valid;
  assign run_clear = (state_q == StIdle) && start;

  // Square is non-negative, so a logical shift truncates toward zero.
  assign err_ext = {{(40 - W){err[W-1]}}, err};
  assign sq      = err_ext * err_ext;
  assign sq_shr  = sq >> 10;

  // One restoring-division step; remainder stays below the divisor (<= 255).
  assign rem_sh  = {rem_q[7:0], quo_q[39]};
  assign rem_ge  = (rem_sh >= Divisor);
  assign rem_nxt = rem_ge ? (rem_sh - Divisor) : rem_sh;
  assign quo_nxt = {quo_q[38:0], rem_ge};

  // Next-state logic for FSM, accumulator and divider.
  always_comb begin
    state_d = state_q;
    sse_d   = sse_q;
    cnt_d   = cnt_q;
    mse_d   = mse_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    bit_d   = bit_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAcc;
          sse_d   = '0;
          cnt_d   = '0;
          mse_d   = '0;
        end
      end
      StAcc: begin
        if (err_valid) begin
          sse_d = sse_q + sq_shr;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LastIdx) begin
            state_d = StDiv;
            quo_d   = sse_d;
            rem_d   = '0;
            bit_d   = '0;
          end
        end
      end
      StDiv: begin
        quo_d = quo_nxt;
        rem_d = rem_nxt;
        bit_d = bit_q + 6'd1;
        if (bit_q == 6'd39) begin
          state_d = StDone;
          mse_d   = (|quo_nxt[39:W]) ? {W{1'b1}} : quo_nxt[W-1:0];
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers, cleared by the asynchronous reset to abort any run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sse_q   <= '0;
      cnt_q   <= '0;
      mse_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      sse_q   <= sse_d;
      cnt_q   <= cnt_d;
      mse_q   <= mse_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      bit_q   <= bit_d;
    end
  end

`ifdef ERR_MAX_TRACK_EN
  logic [W-1:0] abs_err;
  logic [W-1:0] max_abs_q;
  logic [7:0]   max_idx_q;

  // Two's-complement magnitude at W bits; the most negative value maps to itself.
  assign abs_err = err[W-1] ? (~err + 1'b1) : err;

  // Track the strictly larger magnitude so ties keep the earlier index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_abs_q <= '0;
      max_idx_q <= '0;
    end else if (run_clear) begin
      max_abs_q <= '0;
      max_idx_q <= '0;
    end else if (accept && (abs_err > max_abs_q)) begin
      max_abs_q <= abs_err;
      max_idx_q <= cnt_q;
    end
  end

  assign max_abs = max_abs_q;
  assign max_idx = max_idx_q;
`else
  logic unused_max;
  assign unused_max = accept ^ run_clear;
  assign max_abs    = '0;
  assign max_idx    = '0;
`endif

  assign busy       = (state_q == StAcc) || (state_q == StDiv);
  assign done       = (state_q == StDone);
  assign sample_cnt = cnt_q;
  assign sse        = sse_q;
  assign mse        = mse_q;

endmodule

// File: tb/tb_regression_error_stats.sv
// Directed bench for regression_error_stats: uniform, alternating-sign,
// saturating and mixed error vectors, handshake gaps, and mid-run reset.
// Max-tracking expectations follow ERR_MAX_TRACK_EN.
module tb_regression_error_stats;

  localparam int unsigned N = 150;
  localparam int unsigned W = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         err_valid;
  logic [W-1:0] err;
  logic         busy;
  logic         done;
  logic [7:0]   sample_cnt;
  logic [39:0]  sse;
  logic [W-1:0] mse;
  logic [W-1:0] max_abs;
  logic [7:0]   max_idx;

  int unsigned n_checks   = 0;
  int unsigned n_pass     = 0;
  int unsigned done_total = 0;

  regression_error_stats #(
    .N_SAMPLES(N),
    .W        (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .err_valid (err_valid),
    .err       (err),
    .busy      (busy),
    .done      (done),
    .sample_cnt(sample_cnt),
    .sse       (sse),
    .mse       (mse),
    .max_abs   (max_abs),
    .max_idx   (max_idx)
  );

  always #5 clk = ~clk;

  // Count done pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (done === 1'b1) done_total = done_total + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Vector modes: 0 uniform +1.0, 1 alternating +/-2.0, 2 single -512.0 at 37,
  // 3 mixed (small value, -3.0 at 3, +3.0 tie at 7).
  function automatic logic [W-1:0] vec_err(input int mode, input int idx);
    case (mode)
      0: return 20'h00400;
      1: return (idx % 2 == 0) ? 20'h00800 : 20'hFF800;
      2: return (idx == 37) ? 20'h80000 : 20'h00000;
      default: begin
        if (idx == 0) return 20'h00021;
        if (idx == 3) return 20'hFF400;
        if (idx == 7) return 20'h00C00;
        return 20'h00000;
      end
    endcase
  endfunction

  task automatic expected(input int mode, output logic [39:0] e_sse, output logic [W-1:0] e_mse,
                          output logic [W-1:0] e_max, output logic [7:0] e_idx);
    case (mode)
      0: begin e_sse = 40'd153600;    e_mse = 20'h00400; e_max = 20'h00400; e_idx = 8'd0;  end
      1: begin e_sse = 40'd614400;    e_mse = 20'h01000; e_max = 20'h00800; e_idx = 8'd0;  end
      2: begin e_sse = 40'd268435456; e_mse = 20'hFFFFF; e_max = 20'h80000; e_idx = 8'd37; end
      default: begin
        e_sse = 40'd18433; e_mse = 20'd122; e_max = 20'h00C00; e_idx = 8'd3;
      end
    endcase
`ifndef ERR_MAX_TRACK_EN
    e_max = '0;
    e_idx = '0;
`endif
  endtask

  task automatic do_run(input int mode, input bit gaps, input string name);
    logic [39:0]  e_sse;
    logic [W-1:0] e_mse;
    logic [W-1:0] e_max;
    logic [7:0]   e_idx;
    int unsigned  d0;
    int           lat;
    expected(mode, e_sse, e_mse, e_max, e_idx);
    d0 = done_total;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, ".busy_acc"}, {63'd0, busy}, 64'd1);
    check({name, ".cnt_clr"}, {56'd0, sample_cnt}, 64'd0);
    for (int i = 0; i < int'(N); i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        if (i % 20 == 5 && g == 0) g = 1;
        repeat (g) begin
          err_valid = 1'b0;
          err       = 20'h80000;
          start     = (i % 20 == 5);
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
      err_valid = 1'b1;
      err       = vec_err(mode, i);
      @(posedge clk); #1;
    end
    err_valid = 1'b0;
    err       = '0;
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      if (lat == 20) check({name, ".busy_div"}, {63'd0, busy}, 64'd1);
      if (gaps && lat == 10) begin
        start     = 1'b1;
        err_valid = 1'b1;
        err       = 20'h80000;
      end
      @(posedge clk); #1;
      start     = 1'b0;
      err_valid = 1'b0;
      err       = '0;
      lat++;
    end
    check({name, ".done_latency"}, 64'(lat), 64'd41);
    check({name, ".sse"}, {24'd0, sse}, {24'd0, e_sse});
    check({name, ".mse"}, {44'd0, mse}, {44'd0, e_mse});
    check({name, ".cnt"}, {56'd0, sample_cnt}, 64'(N));
    check({name, ".max_abs"}, {44'd0, max_abs}, {44'd0, e_max});
    check({name, ".max_idx"}, {56'd0, max_idx}, {56'd0, e_idx});
    @(posedge clk); #1;
    check({name, ".done_off"}, {63'd0, done}, 64'd0);
    check({name, ".busy_off"}, {63'd0, busy}, 64'd0);
    check({name, ".sse_hold"}, {24'd0, sse}, {24'd0, e_sse});
    check({name, ".mse_hold"}, {44'd0, mse}, {44'd0, e_mse});
    check({name, ".done_pulses"}, 64'(done_total - d0), 64'd1);
  endtask

  task automatic check_zero(input string name);
    check({name, ".busy"}, {63'd0, busy}, 64'd0);
    check({name, ".done"}, {63'd0, done}, 64'd0);
    check({name, ".cnt"}, {56'd0, sample_cnt}, 64'd0);
    check({name, ".sse"}, {24'd0, sse}, 64'd0);
    check({name, ".mse"}, {44'd0, mse}, 64'd0);
    check({name, ".max_abs"}, {44'd0, max_abs}, 64'd0);
    check({name, ".max_idx"}, {56'd0, max_idx}, 64'd0);
  endtask

  initial begin
    int unsigned d0;
    rst       = 1'b1;
    start     = 1'b0;
    err_valid = 1'b0;
    err       = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    do_run(0, 1'b0, "uniform");
    do_run(1, 1'b0, "alternate");
    do_run(2, 1'b0, "saturate");
    do_run(3, 1'b0, "mixed");
    do_run(0, 1'b1, "gaps");

    // Reset after 80 accepted samples, then confirm IDLE ignores err_valid.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 80; i++) begin
      err_valid = 1'b1;
      err       = 20'h00400;
      @(posedge clk); #1;
    end
    check("midrun.cnt80", {56'd0, sample_cnt}, 64'd80);
    d0  = done_total;
    rst = 1'b1;
    #1;
    check_zero("midrun_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    err_valid = 1'b0;
    check_zero("midrun_after");
    check("midrun.no_done", 64'(done_total - d0), 64'd0);

    do_run(0, 1'b0, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
